// File: rtl/button_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// button_pkg : shared types and 100 MHz timing defaults for button_event
// Rev 1.0
// ----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOWN  = 3'd1,
        WAIT2 = 3'd2,
        DOWN2 = 3'd3,
        LONG  = 3'd4
    } btn_state_t;

    // 500 ms long press, 100 ms repeat period, 150 ms double-click gap
    localparam int LONG_CYCLES_DEF   = 50_000_000;
    localparam int REPEAT_CYCLES_DEF = 10_000_000;
    localparam int DCLICK_CYCLES_DEF = 15_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic is_held_state(input btn_state_t s);
        return (s == DOWN) || (s == DOWN2) || (s == LONG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// button_event_if : button level in, gesture event pulses out
// Rev 1.0
// ----------------------------------------------------------------------------
interface button_event_if;

    logic btn;
    logic en;
    logic press;
    logic release_pulse;
    logic click;
    logic dclick;
    logic long_press;
    logic repeat_pulse;
    logic held;

    modport master (
        output btn,
        output en,
        input  press,
        input  release_pulse,
        input  click,
        input  dclick,
        input  long_press,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  btn,
        input  en,
        output press,
        output release_pulse,
        output click,
        output dclick,
        output long_press,
        output repeat_pulse,
        output held
    );

endinterface
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_edge : armed edge detector for a clock-synchronous level input
// Rev 1.0
// ----------------------------------------------------------------------------
module btn_edge (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic btn,
    output logic      rise,
    output logic      fall
);

    logic btn_q;
    logic btn_d;
    logic armed_q;
    logic armed_d;

    always_comb begin
        btn_d   = btn;
        armed_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            btn_q   <= btn_d;
            armed_q <= armed_d;
        end
    end

    // No edge until the first post-reset sample, so a level held through reset is silent
    always_comb begin
        rise = armed_q &  btn & ~btn_q;
        fall = armed_q & ~btn &  btn_q;
    end

endmodule
`default_nettype wire

// File: rtl/button_event.sv
`default_nettype none
// ----------------------------------------------------------------------------
// button_event : classifies a debounced button into press/release/click/
//                double-click/long-press/repeat single-cycle pulses
// Rev 1.0
// ----------------------------------------------------------------------------
module button_event
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int DCLICK_CYCLES = DCLICK_CYCLES_DEF,
    parameter int CNT_W         = $clog2(max3(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES) + 1)
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    button_event_if.slave   bus
);

    // Long threshold compares the current count so the counter reaches
    // LONG_CYCLES-1 on the same edge that raises long_press.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic rise;
    logic fall;

    btn_edge u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.btn),
        .rise  (rise),
        .fall  (fall)
    );

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             dclick_q, dclick_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_ONE;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        dclick_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            press_d = rise;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = DOWN;
                    end
                end
                DOWN: begin
                    if (fall) begin
                        state_d   = WAIT2;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end
                end
                WAIT2: begin
                    // A rise on the final window cycle still wins over the click
                    if (rise) begin
                        state_d = DOWN2;
                        cnt_d   = '0;
                    end else if (cnt_q == DCLICK_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        click_d = 1'b1;
                    end
                end
                DOWN2: begin
                    if (fall) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                        dclick_d  = 1'b1;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end
                end
                LONG: begin
                    if (fall) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (cnt_q == REPEAT_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        held_d = is_held_state(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            dclick_q  <= dclick_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.click         = click_q;
    assign bus.dclick        = dclick_q;
    assign bus.long_press    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_button_event : directed gesture scenarios with LONG=8, REPEAT=4, DCLICK=6
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_button_event;

    localparam int EV_PRESS = 0, EV_REL = 1, EV_CLICK = 2, EV_DCLICK = 3, EV_LONG = 4, EV_REP = 5;

    logic clk;
    logic rst_n;
    int   cyc;
    int   t0;
    int   n_checks;
    int   n_errors;
    int   ev_cnt   [6];
    int   ev_first [6];
    int   ev_last  [6];

    button_event_if bus();

    button_event #(
        .LONG_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .DCLICK_CYCLES (6)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [5:0] v;
        v = {bus.repeat_pulse, bus.long_press, bus.dclick, bus.click, bus.release_pulse, bus.press};
        for (int i = 0; i < 6; i++) begin
            if (v[i]) begin
                if (ev_cnt[i] == 0) ev_first[i] = cyc;
                ev_last[i] = cyc;
                ev_cnt[i]  = ev_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        for (int i = 0; i < 6; i++) begin
            ev_cnt[i]   = 0;
            ev_first[i] = 0;
            ev_last[i]  = 0;
        end
        t0 = cyc;
    endtask

    function automatic int all_outs();
        return {25'd0, bus.held, bus.repeat_pulse, bus.long_press, bus.dclick,
                bus.click, bus.release_pulse, bus.press};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        bus.btn  = 1'b0;
        bus.en   = 1'b1;
        clear_log();
        tick(2);
        check("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        tick(3);

        // Short click: high 3 cycles, fall sampled in cycle 3
        clear_log();
        bus.btn = 1'b1;
        tick(1);
        check("click_held", int'(bus.held), 1);
        tick(2);
        bus.btn = 1'b0;
        tick(15);
        check("click_press_cyc", ev_first[EV_PRESS] - t0, 1);
        check("click_rel_cyc",   ev_first[EV_REL] - t0, 4);
        check("click_click_cyc", ev_first[EV_CLICK] - t0, 10);
        check("click_nclick",    ev_cnt[EV_CLICK], 1);
        check("click_ndclick",   ev_cnt[EV_DCLICK], 0);
        check("click_nlong",     ev_cnt[EV_LONG], 0);
        check("click_held_end",  int'(bus.held), 0);

        // Double click: high 2, low 3, high 2, low
        clear_log();
        bus.btn = 1'b1; tick(2);
        bus.btn = 1'b0; tick(3);
        bus.btn = 1'b1; tick(2);
        bus.btn = 1'b0; tick(15);
        check("dbl_npress",      ev_cnt[EV_PRESS], 2);
        check("dbl_press2_cyc",  ev_last[EV_PRESS] - t0, 6);
        check("dbl_rel2_cyc",    ev_last[EV_REL] - t0, 8);
        check("dbl_dclick_cyc",  ev_first[EV_DCLICK] - t0, 8);
        check("dbl_ndclick",     ev_cnt[EV_DCLICK], 1);
        check("dbl_nclick",      ev_cnt[EV_CLICK], 0);

        // Long press: held 20 cycles
        clear_log();
        bus.btn = 1'b1; tick(20);
        bus.btn = 1'b0; tick(12);
        check("long_cyc",        ev_first[EV_LONG] - t0, 8);
        check("long_nlong",      ev_cnt[EV_LONG], 1);
        check("long_nrep",       ev_cnt[EV_REP], 3);
        check("long_rep_first",  ev_first[EV_REP] - t0, 12);
        check("long_rep_last",   ev_last[EV_REP] - t0, 20);
        check("long_rel_cyc",    ev_first[EV_REL] - t0, 21);
        check("long_nclick",     ev_cnt[EV_CLICK], 0);

        // Second rise exactly DCLICK cycles after the first fall
        clear_log();
        bus.btn = 1'b1; tick(2);
        bus.btn = 1'b0; tick(6);
        bus.btn = 1'b1; tick(2);
        bus.btn = 1'b0; tick(15);
        check("edge6_ndclick",   ev_cnt[EV_DCLICK], 1);
        check("edge6_dclick_cyc", ev_first[EV_DCLICK] - t0, 11);
        check("edge6_nclick",    ev_cnt[EV_CLICK], 0);

        // One cycle later: click, then a fresh single-click gesture
        clear_log();
        bus.btn = 1'b1; tick(2);
        bus.btn = 1'b0; tick(7);
        bus.btn = 1'b1; tick(2);
        bus.btn = 1'b0; tick(15);
        check("edge7_click1_cyc", ev_first[EV_CLICK] - t0, 9);
        check("edge7_press2_cyc", ev_last[EV_PRESS] - t0, 10);
        check("edge7_click2_cyc", ev_last[EV_CLICK] - t0, 18);
        check("edge7_nclick",     ev_cnt[EV_CLICK], 2);
        check("edge7_ndclick",    ev_cnt[EV_DCLICK], 0);

        // Button held through reset, then released
        rst_n   = 1'b0;
        bus.btn = 1'b1;
        tick(2);
        clear_log();
        rst_n = 1'b1;
        tick(10);
        bus.btn = 1'b0;
        tick(12);
        check("hold_rst_npress", ev_cnt[EV_PRESS], 0);
        check("hold_rst_nrel",   ev_cnt[EV_REL], 0);
        check("hold_rst_nclick", ev_cnt[EV_CLICK], 0);
        check("hold_rst_nlong",  ev_cnt[EV_LONG], 0);
        clear_log();
        bus.btn = 1'b1; tick(2);
        bus.btn = 1'b0; tick(12);
        check("tap_npress",      ev_cnt[EV_PRESS], 1);
        check("tap_click_cyc",   ev_first[EV_CLICK] - t0, 9);

        // Asynchronous reset while a repeat pulse is high
        clear_log();
        bus.btn = 1'b1; tick(12);
        check("rst_rep_pre",     int'(bus.repeat_pulse), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_outs",  all_outs(), 0);
        tick(2);
        clear_log();
        rst_n = 1'b1;
        tick(10);
        bus.btn = 1'b0;
        tick(10);
        check("rst_after_nrep",  ev_cnt[EV_REP], 0);
        check("rst_after_nlong", ev_cnt[EV_LONG], 0);
        check("rst_after_nrel",  ev_cnt[EV_REL], 0);

        // Enable dropped for 3 cycles during DOWN, button still held on re-enable
        clear_log();
        bus.btn = 1'b1; tick(3);
        bus.en  = 1'b0; tick(3);
        check("en_off_held",     int'(bus.held), 0);
        bus.en  = 1'b1; tick(3);
        bus.btn = 1'b0; tick(12);
        check("en_npress",       ev_cnt[EV_PRESS], 1);
        check("en_nrel",         ev_cnt[EV_REL], 0);
        check("en_nclick",       ev_cnt[EV_CLICK], 0);
        check("en_nlong",        ev_cnt[EV_LONG], 0);
        check("en_end_outs",     all_outs(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
